// File: rtl/neo_pkg.sv
/*------------------------------------------------------------------
 | neo_pkg -- shared NMI state encoding and reset values for z80_mailbox
 | Rev 1.0
 *------------------------------------------------------------------*/
`default_nettype none

package neo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_EN = 2'd1,
    ST_NMI_ON  = 2'd2
  } nmi_state_t;

  localparam nmi_state_t C_RST_STATE      = ST_IDLE;
  localparam logic [7:0] C_RST_CMD        = 8'h00;
  localparam logic [7:0] C_RST_REPLY      = 8'h00;
  localparam logic       C_RST_FLAG       = 1'b0;
  localparam logic       C_RST_NMI_N      = 1'b1;
  localparam logic       C_RST_STROBE_HIST = 1'b1;

  // Bit positions of each strobe in the top-level strobe vector
  localparam int C_NUM_STROBES = 7;
  localparam int C_EV_SDW      = 0;
  localparam int C_EV_Z80R     = 1;
  localparam int C_EV_Z80CLR   = 2;
  localparam int C_EV_Z80W     = 3;
  localparam int C_EV_RDREPLY  = 4;
  localparam int C_EV_NMI_EN   = 5;
  localparam int C_EV_NMI_DIS  = 6;

  function automatic logic nmi_active(input nmi_state_t s);
    return (s == ST_NMI_ON);
  endfunction

endpackage

`default_nettype wire

// File: rtl/strobe_fall.sv
/*------------------------------------------------------------------
 | strobe_fall -- registered falling-edge detector for an active-low strobe
 | Rev 1.0
 *------------------------------------------------------------------*/
`default_nettype none

module strobe_fall
  import neo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic strobe_n,
  output logic fall
);

  logic r_prev;
  logic r_armed;
  logic r_fall;

  // A strobe held low through reset must be seen high before it can fire again
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= C_RST_STROBE_HIST;
      r_armed <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_prev  <= strobe_n;
      r_armed <= r_armed | strobe_n;
      r_fall  <= r_armed & r_prev & ~strobe_n;
    end
  end

  assign fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/z80_mailbox.sv
/*------------------------------------------------------------------
 | z80_mailbox -- 68K->Z80 command / Z80->68K reply mailbox with NMI handshake
 | Rev 1.0
 *------------------------------------------------------------------*/
`default_nettype none

module z80_mailbox
  import neo_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       nSDW,
  input  logic       nSDRD_REPLY,
  input  logic [7:0] M68K_DATA,
  input  logic       nSDZ80R,
  input  logic       nSDZ80W,
  input  logic       nSDZ80CLR,
  input  logic       nNMI_EN_WR,
  input  logic       nNMI_DIS_WR,
  input  logic [7:0] SDD_IN,
  output logic [7:0] SDD_CMD,
  output logic [7:0] M68K_REPLY,
  output logic       nZ80NMI,
  output logic       CMD_PENDING,
  output logic       REPLY_VALID,
  output logic       OVERRUN
);

  logic [C_NUM_STROBES-1:0] w_strobe_n;
  logic [C_NUM_STROBES-1:0] w_fall;

  assign w_strobe_n[C_EV_SDW]     = nSDW;
  assign w_strobe_n[C_EV_Z80R]    = nSDZ80R;
  assign w_strobe_n[C_EV_Z80CLR]  = nSDZ80CLR;
  assign w_strobe_n[C_EV_Z80W]    = nSDZ80W;
  assign w_strobe_n[C_EV_RDREPLY] = nSDRD_REPLY;
  assign w_strobe_n[C_EV_NMI_EN]  = nNMI_EN_WR;
  assign w_strobe_n[C_EV_NMI_DIS] = nNMI_DIS_WR;

  for (genvar gi = 0; gi < C_NUM_STROBES; gi++) begin : g_strobe
    strobe_fall u_fall (
      .clk      (CLK),
      .rst      (RESET),
      .strobe_n (w_strobe_n[gi]),
      .fall     (w_fall[gi])
    );
  end

  logic w_wr, w_rd, w_clr, w_zw, w_rr, w_en_set, w_en_clr;
  assign w_wr     = w_fall[C_EV_SDW];
  assign w_rd     = w_fall[C_EV_Z80R];
  assign w_clr    = w_fall[C_EV_Z80CLR];
  assign w_zw     = w_fall[C_EV_Z80W];
  assign w_rr     = w_fall[C_EV_RDREPLY];
  assign w_en_set = w_fall[C_EV_NMI_EN];
  assign w_en_clr = w_fall[C_EV_NMI_DIS];

  logic [7:0] r_cmd, w_cmd_next;
  logic [7:0] r_reply, w_reply_next;
  logic       r_pend, w_pend_next;
  logic       r_valid, w_valid_next;
  logic       r_ovr, w_ovr_next;
  logic       r_en, w_en_next;
  logic       w_en_rise;
  logic       r_nmi_n;
  nmi_state_t r_state, w_state_next;

  // Mailbox datapath: a 68K write always beats a same-cycle Z80 read/clear
  always_comb begin
    w_cmd_next   = r_cmd;
    w_pend_next  = r_pend;
    w_ovr_next   = r_ovr;
    w_reply_next = r_reply;
    w_valid_next = r_valid;
    w_en_next    = r_en;

    if (w_wr) begin
      w_cmd_next  = M68K_DATA;
      w_pend_next = 1'b1;
      if (r_pend && !(w_rd || w_clr)) begin
        w_ovr_next = 1'b1;
      end
    end else if (w_clr) begin
      w_cmd_next  = 8'h00;
      w_pend_next = 1'b0;
    end else if (w_rd) begin
      w_pend_next = 1'b0;
    end

    if (w_zw) begin
      w_reply_next = SDD_IN;
      w_valid_next = 1'b1;
    end else if (w_rr) begin
      w_valid_next = 1'b0;
    end

    if (w_en_clr) begin
      w_en_next = 1'b0;
    end else if (w_en_set) begin
      w_en_next = 1'b1;
    end
  end

  assign w_en_rise = w_en_next & ~r_en;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_wr) begin
          w_state_next = w_en_next ? ST_NMI_ON : ST_WAIT_EN;
        end else if (w_en_rise && w_pend_next) begin
          w_state_next = ST_NMI_ON;
        end
      end
      ST_WAIT_EN: begin
        // Z80 may poll and consume the command before ever enabling NMI
        if (!w_pend_next) begin
          w_state_next = ST_IDLE;
        end else if (w_en_next) begin
          w_state_next = ST_NMI_ON;
        end
      end
      ST_NMI_ON: begin
        if (!w_en_next || !w_pend_next) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= C_RST_STATE;
      r_nmi_n <= C_RST_NMI_N;
    end else begin
      r_state <= w_state_next;
      r_nmi_n <= ~nmi_active(w_state_next);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cmd   <= C_RST_CMD;
      r_reply <= C_RST_REPLY;
      r_pend  <= C_RST_FLAG;
      r_valid <= C_RST_FLAG;
      r_ovr   <= C_RST_FLAG;
      r_en    <= C_RST_FLAG;
    end else begin
      r_cmd   <= w_cmd_next;
      r_reply <= w_reply_next;
      r_pend  <= w_pend_next;
      r_valid <= w_valid_next;
      r_ovr   <= w_ovr_next;
      r_en    <= w_en_next;
    end
  end

  assign SDD_CMD     = r_cmd;
  assign M68K_REPLY  = r_reply;
  assign nZ80NMI     = r_nmi_n;
  assign CMD_PENDING = r_pend;
  assign REPLY_VALID = r_valid;
  assign OVERRUN     = r_ovr;

endmodule

`default_nettype wire

// File: doc/z80_mailbox.md
Z80_MAILBOX -- requirements
Module: z80_mailbox

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have ports: RESET  in  1  synchronous reset, active-high.
REQ-003 SHALL have ports: nSDW  in  1  68K command-write strobe, active low.
REQ-004 SHALL have ports: nSDRD_REPLY  in  1  68K reply-read strobe, active low.
REQ-005 SHALL have ports: M68K_DATA  in  8  68K write data.
REQ-006 SHALL have ports: nSDZ80R  in  1  Z80 command-read strobe, active low.
REQ-007 SHALL have ports: nSDZ80W  in  1  Z80 reply-write strobe, active low.
REQ-008 SHALL have ports: nSDZ80CLR  in  1  Z80 command-clear strobe, active low.
REQ-009 SHALL have ports: nNMI_EN_WR / nNMI_DIS_WR  in  1 each  Z80 NMI enable/disable port strobes, active low.
REQ-010 SHALL have ports: SDD_IN  in  8  Z80 write data.
REQ-011 SHALL have ports: SDD_CMD  out  8  command byte to Z80 bus.
REQ-012 SHALL have ports: M68K_REPLY  out  8  reply byte to 68K bus.
REQ-013 SHALL have ports: nZ80NMI  out  1  NMI to Z80, active low.
REQ-014 SHALL have ports: CMD_PENDING, REPLY_VALID, OVERRUN  out  1 each  status flags.

Function
REQ-015 All strobes SHALL be registered; actions occur on the falling edge (current low, previous high), result visible on outputs 1 CLK after the detected edge.
REQ-016 On nSDW edge: SDD_CMD <= M68K_DATA; CMD_PENDING <= 1; if CMD_PENDING was already 1 and no Z80 read occurs the same cycle, OVERRUN <= 1 (sticky).
REQ-017 On nSDZ80R edge: CMD_PENDING <= 0; SDD_CMD unchanged.
REQ-018 On nSDZ80CLR edge: SDD_CMD <= 0; CMD_PENDING <= 0.
REQ-019 On nSDZ80W edge: M68K_REPLY <= SDD_IN; REPLY_VALID <= 1.
REQ-020 On nSDRD_REPLY edge: REPLY_VALID <= 0; M68K_REPLY unchanged.
REQ-021 Simultaneous nSDW and nSDZ80R/nSDZ80CLR edges: 68K write wins; new byte latched, CMD_PENDING = 1, no OVERRUN.
REQ-022 Simultaneous nSDZ80W and nSDRD_REPLY edges: write wins; REPLY_VALID = 1.
REQ-023 NMI_EN register: set by nNMI_EN_WR edge, cleared by nNMI_DIS_WR edge; both at once -> cleared.
REQ-024 NMI FSM states IDLE, WAIT_EN, NMI_ON.
REQ-025 IDLE -> WAIT_EN on command write with NMI_EN = 0; IDLE -> NMI_ON on command write with NMI_EN = 1.
REQ-026 WAIT_EN -> NMI_ON when NMI_EN becomes 1.
REQ-027 NMI_ON -> IDLE on Z80 read or clear edge.
REQ-028 NMI_ON -> IDLE when NMI_EN is cleared, dropping the NMI; CMD_PENDING is retained.
REQ-029 In NMI_ON, a new command write keeps the FSM in NMI_ON with nZ80NMI held low.
REQ-030 nZ80NMI SHALL be 0 exactly while the FSM is in NMI_ON, driven from a register with no combinational path.
REQ-031 A rising edge of NMI_EN while CMD_PENDING = 1 and the FSM is in IDLE SHALL go to NMI_ON, since a pending command re-raises the NMI.

Reset
REQ-032 While RESET = 1, all CLK edges SHALL set: SDD_CMD = 0, M68K_REPLY = 0, all flags 0, NMI_EN = 0, FSM = IDLE, nZ80NMI = 1, and strobe history registers = 1 (no false edge after release).
REQ-033 Reset mid-handshake (FSM in NMI_ON) SHALL release nZ80NMI on the first CLK edge with RESET high.

Structure
REQ-034 FSM state encoding and the reset values SHALL live in the shared package neo_pkg.
REQ-035 One sub-module, strobe_fall, SHALL be instantiated once per strobe; it is a 1-bit registered falling-edge detector with synchronous active-high reset preset to 1.

Verification
REQ-036 Reset, NMI_EN = 1, 68K writes 0x5A -> after 1 CLK SDD_CMD = 0x5A, CMD_PENDING = 1, nZ80NMI = 0; Z80 read -> nZ80NMI = 1, CMD_PENDING = 0.
REQ-037 NMI_EN = 0, 68K writes 0x11 -> nZ80NMI stays 1; enable strobe -> nZ80NMI = 0 one CLK later.
REQ-038 68K writes 0x01 then 0x02 with no Z80 read -> SDD_CMD = 0x02, OVERRUN = 1; OVERRUN stays 1 after a Z80 read until RESET.
REQ-039 68K write 0x33 and Z80 read on the same CLK -> SDD_CMD = 0x33, CMD_PENDING = 1, OVERRUN = 0, nZ80NMI = 0.
REQ-040 Z80 writes 0xA5 -> M68K_REPLY = 0xA5, REPLY_VALID = 1; 68K reply read -> REPLY_VALID = 0, M68K_REPLY = 0xA5.
REQ-041 RESET asserted for 1 CLK while nZ80NMI = 0 and strobes are held low -> all outputs at reset values, and no action after release until each strobe goes high and low again.
